// File: rtl/mem_arbiter_n_if.sv
// Request/response and byte-serial RAM bus bundle for mem_arbiter_n.
// "master" is the requester/RAM side; "slave" is the arbiter.
interface mem_arbiter_n_if #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_rw;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*3-1:0]          req_len;
  logic [NUM_PORTS*32-1:0]         req_wdata;
  logic [NUM_PORTS-1:0]            req_cancel;
  logic [NUM_PORTS-1:0]            grant;
  logic [NUM_PORTS-1:0]            done;
  logic [31:0]                     rdata;
  logic                            busy;
  logic [7:0]                      ram_data_i;
  logic [7:0]                      ram_data_o;
  logic [31:0]                     ram_addr;
  logic                            ram_rw_sel;
  logic                            io_buffer_full;

  modport master (
    output req_valid, req_rw, req_addr, req_len, req_wdata, req_cancel,
    output ram_data_i, io_buffer_full,
    input  grant, done, rdata, busy, ram_data_o, ram_addr, ram_rw_sel
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_len, req_wdata, req_cancel,
    input  ram_data_i, io_buffer_full,
    output grant, done, rdata, busy, ram_data_o, ram_addr, ram_rw_sel
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// N-port arbiter onto the byte-serial RAM/IO bus: 1/2/4-byte little-endian
// transfers, fixed or round-robin arbitration, UART throttling, read cancel.
module mem_arbiter_n #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  mem_arbiter_n_if.slave bus
);
  localparam int unsigned OW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_IO_WAIT} state_t;

  state_t                state, state_nxt;
  logic [OW-1:0]         rr_ptr, rr_ptr_nxt;
  logic [NUM_PORTS-1:0]  grant_q, grant_nxt;
  logic [NUM_PORTS-1:0]  done_q, done_nxt;
  logic [31:0]           rdata_q, rdata_nxt;
  logic [31:0]           ram_addr_q, ram_addr_nxt;
  logic [7:0]            ram_data_q, ram_data_nxt;
  logic                  rw_sel_q, rw_sel_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
  logic [2:0]            lat_len, lat_len_nxt;
  logic [31:0]           lat_wdata, lat_wdata_nxt;

  logic [ADDR_WIDTH-1:0] p_addr  [NUM_PORTS];
  logic [2:0]            p_len   [NUM_PORTS];
  logic [31:0]           p_wdata [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign p_addr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign p_len[g]   = bus.req_len[g*3 +: 3];
    assign p_wdata[g] = bus.req_wdata[g*32 +: 32];
  end

  function automatic logic [2:0] norm_len(input logic [2:0] l);
    case (l)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  logic [NUM_PORTS-1:0] eligible;
  logic                 win_found;
  logic [OW-1:0]        win_idx;
  logic [OW-1:0]        cand;
  logic                 win_rw, win_io, accept, is_io, cancel_own;
  logic [1:0]           rbyte, wbyte;

  // Scan downwards so the last hit (lowest index / nearest after rr_ptr) wins.
  always_comb begin
    eligible  = bus.req_valid & ~bus.req_cancel;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = NUM_PORTS; i > 0; i--) begin
        if (eligible[OW'(i-1)]) begin
          win_found = 1'b1;
          win_idx   = OW'(i-1);
        end
      end
    end else begin
      for (int unsigned k = NUM_PORTS; k > 0; k--) begin
        cand = OW'((32'(rr_ptr) + k) % NUM_PORTS);
        if (eligible[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign win_rw     = bus.req_rw[win_idx];
  assign win_io     = (p_addr[win_idx][17:16] == 2'b11);
  assign accept     = (state == S_IDLE) && win_found && (done_q == '0);
  assign is_io      = (lat_addr[17:16] == 2'b11);
  assign cancel_own = |(bus.req_cancel & grant_q);
  assign rbyte      = 2'(cnt - 3'd2);
  assign wbyte      = cnt[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= OW'(NUM_PORTS-1);
      grant_q    <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      rw_sel_q   <= 1'b0;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_len    <= '0;
      lat_wdata  <= '0;
    end else if (rdy) begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_q    <= grant_nxt;
      done_q     <= done_nxt;
      rdata_q    <= rdata_nxt;
      ram_addr_q <= ram_addr_nxt;
      ram_data_q <= ram_data_nxt;
      rw_sel_q   <= rw_sel_nxt;
      cnt        <= cnt_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_len    <= lat_len_nxt;
      lat_wdata  <= lat_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (accept) state_nxt = win_rw ? S_WRITE : S_READ;
      S_READ:    if (cancel_own || cnt == lat_len + 3'd1) state_nxt = S_IDLE;
      S_WRITE: begin
        if (cnt == lat_len)                     state_nxt = S_IDLE;
        else if (is_io && !bus.io_buffer_full)  state_nxt = S_IO_WAIT;
      end
      S_IO_WAIT: state_nxt = S_WRITE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // cnt is the index of the upcoming edge in READ and the bytes issued in WRITE.
  always_comb begin
    grant_nxt     = grant_q;
    done_nxt      = '0;
    rdata_nxt     = rdata_q;
    ram_addr_nxt  = ram_addr_q;
    ram_data_nxt  = ram_data_q;
    rw_sel_nxt    = 1'b0;
    cnt_nxt       = cnt;
    lat_addr_nxt  = lat_addr;
    lat_len_nxt   = lat_len;
    lat_wdata_nxt = lat_wdata;
    rr_ptr_nxt    = rr_ptr;
    unique case (state)
      S_IDLE: begin
        grant_nxt = '0;
        if (accept) begin
          grant_nxt[win_idx] = 1'b1;
          rr_ptr_nxt         = win_idx;
          lat_addr_nxt       = p_addr[win_idx];
          lat_len_nxt        = norm_len(p_len[win_idx]);
          lat_wdata_nxt      = p_wdata[win_idx];
          rdata_nxt          = '0;
          ram_addr_nxt       = 32'(p_addr[win_idx]);
          cnt_nxt            = 3'd1;
          if (win_rw) begin
            if (win_io) begin
              cnt_nxt = 3'd0;
            end else begin
              ram_data_nxt = p_wdata[win_idx][7:0];
              rw_sel_nxt   = 1'b1;
            end
          end
        end
      end
      S_READ: begin
        if (cancel_own) begin
          grant_nxt = '0;
        end else begin
          if (cnt < lat_len)   ram_addr_nxt = 32'(lat_addr + ADDR_WIDTH'(cnt));
          if (cnt >= 3'd2)     rdata_nxt[{rbyte, 3'b000} +: 8] = bus.ram_data_i;
          if (cnt == lat_len + 3'd1) done_nxt = grant_q;
          cnt_nxt = cnt + 3'd1;
        end
      end
      S_WRITE: begin
        if (cnt == lat_len) begin
          done_nxt = grant_q;
        end else if (!is_io || !bus.io_buffer_full) begin
          ram_addr_nxt = 32'(lat_addr + ADDR_WIDTH'(cnt));
          ram_data_nxt = lat_wdata[{wbyte, 3'b000} +: 8];
          rw_sel_nxt   = 1'b1;
          cnt_nxt      = cnt + 3'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_data_o = ram_data_q;
  assign bus.ram_rw_sel = rw_sel_q;
endmodule
